// File: rtl/ibex_fetch_req_ctrl.sv
// rtl/ibex_fetch_req_ctrl.sv - instruction-bus request controller feeding the fetch FIFO
//
// Issues word requests on the instruction bus, tracks up to two outstanding
// requests, tags each response with its fetch address and per-halfword
// exception bits, and drops responses to requests issued before a redirect.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   req_i                         fetch enable
//   branch_i, branch_addr_i       single-cycle redirect and its target
//   pcc_base_i, pcc_top_i         fetch bounds [base, top)
//   instr_req_o, instr_addr_o     bus request and word-aligned address
//   instr_gnt_i                   bus grant
//   instr_rvalid_i, instr_rdata_i, instr_err_i   bus response
//   fifo_ready_i                  FIFO has room for two more words
//   fifo_valid_o, fifo_addr_o, fifo_rdata_o, fifo_exc_o   FIFO write port
//   fifo_clear_o                  FIFO flush on redirect
//   busy_o                        request pending or response outstanding

`ifndef EXCEPTION_SIZE
`define EXCEPTION_SIZE 2
`endif

module ibex_fetch_req_ctrl #(
    parameter int unsigned EXC_W      = `EXCEPTION_SIZE,
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  branch_i,
    input  logic [31:0]           branch_addr_i,
    input  logic [31:0]           pcc_base_i,
    input  logic [31:0]           pcc_top_i,
    output logic                  instr_req_o,
    output logic [31:0]           instr_addr_o,
    input  logic                  instr_gnt_i,
    input  logic                  instr_rvalid_i,
    input  logic [31:0]           instr_rdata_i,
    input  logic                  instr_err_i,
    input  logic                  fifo_ready_i,
    output logic                  fifo_valid_o,
    output logic [31:0]           fifo_addr_o,
    output logic [31:0]           fifo_rdata_o,
    output logic [1:0][EXC_W-1:0] fifo_exc_o,
    output logic                  fifo_clear_o,
    output logic                  busy_o
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_addr_q, fetch_addr_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic        stale_q, stale_d;
    logic [1:0]  outstanding_q, outstanding_d;
    logic [1:0]  discard_cnt_q, discard_cnt_d;

    // Two-entry response tag queue; entry 0 is the head.
    logic [31:0] tag_addr_q [2];
    logic [31:0] tag_addr_d [2];
    logic [1:0]  tag_lo_q, tag_lo_d;
    logic [1:0]  tag_hi_q, tag_hi_d;

    logic        gnt_fire;
    logic        rvalid_fire;
    logic        issue_ok;
    logic [31:0] req_word;
    logic [32:0] req_word_p2;
    logic        lo_oob;
    logic        hi_oob;
    logic        wr_idx;

    assign gnt_fire    = (state_q == REQ) && instr_gnt_i;
    // A response with nothing outstanding (e.g. left over from before a reset)
    // is ignored everywhere.
    assign rvalid_fire = instr_rvalid_i && (outstanding_q != 2'd0);

    always_comb begin
        outstanding_d = outstanding_q;
        if (gnt_fire && !rvalid_fire) begin
            outstanding_d = outstanding_q + 2'd1;
        end else if (!gnt_fire && rvalid_fire) begin
            outstanding_d = outstanding_q - 2'd1;
        end
    end

    // Using the post-grant count keeps outstanding at or below two.
    assign issue_ok = req_i && fifo_ready_i && (outstanding_d < 2'd2) && !branch_i;

    // Bounds of the word being requested, captured into the queue at grant.
    assign req_word    = {req_addr_q[31:2], 2'b00};
    assign req_word_p2 = {1'b0, req_word} + 33'd2;
    assign lo_oob      = (req_word < pcc_base_i) || (req_word >= pcc_top_i);
    assign hi_oob      = (req_word_p2 < {1'b0, pcc_base_i}) || (req_word_p2 >= {1'b0, pcc_top_i});

    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        req_addr_d   = req_addr_q;
        stale_d      = stale_q;

        if (branch_i) begin
            fetch_addr_d = branch_addr_i;
        end else if (gnt_fire && !stale_q) begin
            // Sequential fetch drops the halfword offset of a branch target.
            fetch_addr_d = {fetch_addr_q[31:2] + 30'd1, 2'b00};
        end

        case (state_q)
            IDLE: begin
                if (issue_ok) begin
                    state_d    = REQ;
                    req_addr_d = fetch_addr_q;
                    stale_d    = 1'b0;
                end
            end
            REQ: begin
                if (instr_gnt_i) begin
                    stale_d = 1'b0;
                    if (issue_ok) begin
                        // After a stale grant fetch_addr_d is the branch target.
                        req_addr_d = fetch_addr_d;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (branch_i) begin
                    // An ungranted request is never retargeted; it is marked
                    // so that its response gets discarded.
                    stale_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        discard_cnt_d = discard_cnt_q;
        if (branch_i) begin
            // Everything in flight after this cycle predates the redirect,
            // including a request granted in the branch cycle itself.
            discard_cnt_d = outstanding_d;
        end else begin
            if (rvalid_fire && (discard_cnt_q != 2'd0)) begin
                discard_cnt_d = discard_cnt_d - 2'd1;
            end
            if (gnt_fire && stale_q) begin
                discard_cnt_d = discard_cnt_d + 2'd1;
            end
        end
    end

    // Slot written on grant: behind the surviving entries after any pop.
    assign wr_idx = (outstanding_q == 2'd1) && !rvalid_fire;

    always_comb begin
        tag_addr_d[0] = tag_addr_q[0];
        tag_addr_d[1] = tag_addr_q[1];
        tag_lo_d      = tag_lo_q;
        tag_hi_d      = tag_hi_q;
        if (rvalid_fire) begin
            tag_addr_d[0] = tag_addr_q[1];
            tag_lo_d[0]   = tag_lo_q[1];
            tag_hi_d[0]   = tag_hi_q[1];
        end
        if (gnt_fire) begin
            tag_addr_d[wr_idx] = req_addr_q;
            tag_lo_d[wr_idx]   = lo_oob;
            tag_hi_d[wr_idx]   = hi_oob;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            fetch_addr_q  <= RESET_ADDR;
            req_addr_q    <= RESET_ADDR;
            stale_q       <= 1'b0;
            outstanding_q <= 2'd0;
            discard_cnt_q <= 2'd0;
            tag_addr_q[0] <= 32'h0;
            tag_addr_q[1] <= 32'h0;
            tag_lo_q      <= 2'b00;
            tag_hi_q      <= 2'b00;
        end else begin
            state_q       <= state_d;
            fetch_addr_q  <= fetch_addr_d;
            req_addr_q    <= req_addr_d;
            stale_q       <= stale_d;
            outstanding_q <= outstanding_d;
            discard_cnt_q <= discard_cnt_d;
            tag_addr_q[0] <= tag_addr_d[0];
            tag_addr_q[1] <= tag_addr_d[1];
            tag_lo_q      <= tag_lo_d;
            tag_hi_q      <= tag_hi_d;
        end
    end

    always_comb begin
        fifo_exc_o       = '0;
        fifo_exc_o[0][0] = instr_err_i;
        fifo_exc_o[1][0] = instr_err_i;
        fifo_exc_o[0][1] = tag_lo_q[0];
        fifo_exc_o[1][1] = tag_hi_q[0];
    end

    assign instr_req_o  = (state_q == REQ);
    assign instr_addr_o = {req_addr_q[31:2], 2'b00};
    assign fifo_valid_o = rvalid_fire && (discard_cnt_q == 2'd0) && !branch_i;
    assign fifo_addr_o  = tag_addr_q[0];
    assign fifo_rdata_o = instr_rdata_i;
    assign fifo_clear_o = branch_i;
    assign busy_o       = instr_req_o || (outstanding_q != 2'd0);

endmodule
